vga_timing_sequencer: RTL

// Parametrised video timing generator plus per-line render sequencer for the display pipeline.

---
 rtl/vga_timing_sequencer_pkg.sv | 41 ++++
 rtl/vga_timing_sequencer_axis.sv | 53 +++++
 rtl/vga_timing_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_sequencer_pkg
// Brief  : Shared video-mode timing types, reference mode and width helpers.
// Rev    : 1.0  initial release
// ============================================================================
package vga_timing_sequencer_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } mode_timing_t;

  localparam mode_timing_t c_mode_640x480_60 = '{
    h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
    v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33}
  };

  typedef enum logic [0:0] {
    SEQ_IDLE  = 1'b0,
    SEQ_ARMED = 1'b1
  } seq_state_t;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int count_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_sequencer_axis.sv
`default_nettype none
// ============================================================================
// Module : vga_axis_counter
// Brief  : One timing axis: wrapping position counter with active/sync decode.
// Rev    : 1.0  initial release
// ============================================================================
module vga_axis_counter
  import vga_timing_sequencer_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP),
  localparam int W     = count_width(TOTAL)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         last,
  output logic         active,
  output logic         sync
);

  localparam logic [W-1:0] c_last    = W'(TOTAL - 1);
  localparam int           c_sync_lo = ACTIVE + FP;
  localparam int           c_sync_hi = ACTIVE + FP + SYNC;

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_count <= '0;
    else if (clear)
      r_count <= '0;
    else if (step)
      r_count <= (r_count == c_last) ? '0 : r_count + W'(1);
  end

  // Decode straight off the register so sync/blank line up with count.
  always_comb begin
    last   = (r_count == c_last);
    active = (32'(r_count) < ACTIVE);
    sync   = ((32'(r_count) >= c_sync_lo) && (32'(r_count) < c_sync_hi)) ? POL : ~POL;
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/vga_timing_sequencer.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_sequencer
// Brief  : Parametrised VGA timing generator with per-line render sequencing,
//          gated line-buffer swap and underrun counting.
// Rev    : 1.0  initial release
// ============================================================================
module vga_timing_sequencer
  import vga_timing_sequencer_pkg::*;
#(
  parameter int H_ACTIVE = int'(c_mode_640x480_60.h.active),
  parameter int H_FP     = int'(c_mode_640x480_60.h.fp),
  parameter int H_SYNC   = int'(c_mode_640x480_60.h.sync),
  parameter int H_BP     = int'(c_mode_640x480_60.h.bp),
  parameter int V_ACTIVE = int'(c_mode_640x480_60.v.active),
  parameter int V_FP     = int'(c_mode_640x480_60.v.fp),
  parameter int V_SYNC   = int'(c_mode_640x480_60.v.sync),
  parameter int V_BP     = int'(c_mode_640x480_60.v.bp),
  parameter int CLK_DIV  = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int SWAP_X   = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 2,
  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int XW      = count_width(H_TOTAL),
  localparam int YW      = count_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          render_done,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_tick,
  output logic          render_start,
  output logic [YW-1:0] render_line,
  output logic          buf_sel,
  output logic          underrun,
  output logic [7:0]    underrun_cnt,
  output logic          frame_start,
  output logic          vblank,
  output logic          VGA_CLK,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_n,
  output logic          VGA_SYNC_n
);

  localparam int            DW         = count_width(CLK_DIV);
  localparam logic [DW-1:0] c_div_last = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] c_div_half = DW'(CLK_DIV / 2);
  localparam logic [XW-1:0] c_swap_x   = XW'(SWAP_X);

  logic [DW-1:0] r_div;
  logic          w_run;
  logic          w_h_last, w_v_last, w_h_active, w_v_active, w_v_step;
  logic [YW-1:0] w_next_y;
  logic          w_renders_next, w_line_start, w_swap_point, w_swap, w_underrun;
  seq_state_t    r_state, w_state_next;
  logic          r_render_start, r_buf_sel;
  logic [YW-1:0] r_render_line;
  logic [7:0]    r_underrun_cnt;

  assign w_run = enable & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_div <= '0;
    else if (!enable)
      r_div <= '0;
    else
      r_div <= (r_div == c_div_last) ? '0 : r_div + DW'(1);
  end

  assign pix_tick = w_run & (r_div == c_div_last);
  assign w_v_step = pix_tick & w_h_last;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .POL (HS_POL)
  ) u_h_axis (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (~enable),
    .step   (pix_tick),
    .count  (pix_x),
    .last   (w_h_last),
    .active (w_h_active),
    .sync   (VGA_HS)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .POL (VS_POL)
  ) u_v_axis (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (~enable),
    .step   (w_v_step),
    .count  (pix_y),
    .last   (w_v_last),
    .active (w_v_active),
    .sync   (VGA_VS)
  );

  assign VGA_CLK     = (r_div >= c_div_half);
  assign VGA_BLANK_n = w_h_active & w_v_active & w_run;
  assign VGA_SYNC_n  = 1'b0;
  assign vblank      = ~w_v_active;
  assign frame_start = w_run & (r_div == '0) & (pix_x == '0) & (pix_y == '0);

  // Rendering runs one line ahead of scan-out, so the last vblank line
  // schedules line 0 of the coming frame.
  assign w_next_y       = w_v_last ? '0 : pix_y + YW'(1);
  assign w_renders_next = (32'(w_next_y) < V_ACTIVE);
  assign w_line_start   = w_run & (r_div == '0) & (pix_x == '0);
  assign w_swap_point   = pix_tick & (pix_x == c_swap_x);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= SEQ_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_swap       = 1'b0;
    case (r_state)
      SEQ_IDLE:  if (w_line_start && w_renders_next) w_state_next = SEQ_ARMED;
      SEQ_ARMED: if (w_swap_point) begin
                   w_swap       = 1'b1;
                   w_state_next = SEQ_IDLE;
                 end
    endcase
    if (!enable)
      w_state_next = SEQ_IDLE;
  end

  assign w_underrun = w_swap & ~render_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_render_start <= 1'b0;
      r_render_line  <= '0;
      r_buf_sel      <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_render_start <= w_line_start & w_renders_next;
      if (w_line_start && w_renders_next)
        r_render_line <= w_next_y;
      if (w_swap && render_done)
        r_buf_sel <= ~r_buf_sel;
      if (frame_start)
        r_underrun_cnt <= {7'd0, w_underrun};
      else if (w_underrun && (r_underrun_cnt != 8'hFF))
        r_underrun_cnt <= r_underrun_cnt + 8'd1;
    end
  end

  assign render_start = r_render_start;
  assign render_line  = r_render_line;
  assign buf_sel      = r_buf_sel;
  assign underrun     = w_underrun;
  assign underrun_cnt = r_underrun_cnt;

endmodule
`default_nettype wire
